sdram_arbiter: RTL and testbench
================================

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter: ADDR_WIDTH, 25, byte address width on all ports.
REQ-002 The block SHALL have a single clock and an asynchronous, active-high reset; all state SHALL be clocked on the rising edge of clk.
REQ-003 clk  in  1  system clock, shared with the SDRAM controller.
REQ-004 reset  in  1  async active-high reset.
REQ-005 a_access  in  1  port A request, held until a_ack.
REQ-006 a_wr_en  in  1  port A write (1) / read (0).
REQ-007 a_addr  in  ADDR_WIDTH  port A byte address.
REQ-008 a_data_in  in  16  port A write data.
REQ-009 a_bytesel  in  2  port A byte enables.
REQ-010 a_data_out  out  16  port A read data.
REQ-011 a_ack  out  1  port A completion pulse.
REQ-012 b_access, b_wr_en, b_addr, b_data_in, b_bytesel, b_data_out, b_ack SHALL mirror REQ-005..011 for port B.
REQ-013 m_oe  out  1  controller request.
REQ-014 m_we  out  1  controller write qualifier.
REQ-015 m_addr  out  ADDR_WIDTH  controller address.
REQ-016 m_din  out  16  controller write data.
REQ-017 m_bytesel  out  2  controller byte enables.
REQ-018 m_dout  in  16  controller read data.
REQ-019 m_ack  in  1  controller ack; may stay high for up to 3 cycles.
REQ-020 m_configdone  in  1  controller initialisation complete.

Function
REQ-021 The FSM SHALL have three states: IDLE, BUSY and DRAIN.
REQ-022 IDLE SHALL grant only when m_configdone=1, m_ack=0 and at least one access is high; on grant, at the next edge: latch the winner's wr_en/addr/data_in/bytesel onto m_*, set m_oe=1, m_we=wr_en, go to BUSY.
REQ-023 All m_* outputs SHALL be registered; m_oe SHALL rise exactly 1 cycle after the request is sampled in IDLE.
REQ-024 Arbitration SHALL be round-robin: on contention, grant the port not granted last; a sole requester SHALL always win; last_grant resets to B, so A wins the first tie.
REQ-025 m_addr, m_din, m_bytesel and m_we SHALL be held stable throughout BUSY regardless of requester input changes.
REQ-026 In BUSY, on the first cycle with m_ack=1, at the next edge: m_oe<=0, m_we<=0, granted x_ack<=1, x_data_out<=m_dout if the access was a read, state<=DRAIN.
REQ-027 x_data_out SHALL be unchanged by writes and by accesses granted to the other port.
REQ-028 x_ack SHALL be exactly one cycle wide; the non-granted port's ack SHALL stay 0.
REQ-029 DRAIN SHALL clear x_ack and stay until m_ack=0, then go to IDLE; no new grant SHALL be issued while m_ack=1, which absorbs the controller's extended ack.
REQ-030 A requester still asserting access in the cycle after its ack SHALL be treated as a new request.
REQ-031 If m_configdone falls, grants in progress SHALL complete; no new grant SHALL issue until it returns high.
REQ-032 Minimum turnaround SHALL be request sample to x_ack = 2 cycles + controller latency; back-to-back accesses SHALL be separated by at least 1 DRAIN cycle.

Reset
REQ-033 While reset=1: state=IDLE, last_grant=B, m_oe=0, m_we=0, m_addr=0, m_din=0, m_bytesel=0, a_ack=b_ack=0, a_data_out=b_data_out=0.
REQ-034 Reset asserted mid-access SHALL drop m_oe immediately (asynchronously); after release, IDLE SHALL wait for m_ack=0 before granting.

Verification
REQ-035 m_configdone=0, a_access=1 -> m_oe stays 0; raise m_configdone -> m_oe=1 one cycle later with m_addr=a_addr.
REQ-036 A read of 0x000100, controller returns m_dout=0xBEEF with m_ack high for 3 cycles -> a_ack pulses 1 cycle, a_data_out=0xBEEF, m_oe low from the first ack cycle, no re-grant until m_ack=0.
REQ-037 a_access and b_access both held continuously -> grants alternate A,B,A,B; each port's ack count differs by at most 1.
REQ-038 B write 0x1234, bytesel=01 -> m_we=1, m_din=0x1234, m_bytesel=01; b_data_out unchanged; b_ack single pulse.
REQ-039 Change a_addr during BUSY -> m_addr holds the original value until m_oe falls.
REQ-040 Assert reset in BUSY while m_ack=1 -> m_oe=0 immediately; after release with m_ack still high, no grant until m_ack=0.

Source files
------------

// File: rtl/sdram_arbiter.sv
// Two-port round-robin arbiter in front of a single SDRAM controller request port.
// Absorbs the controller's extended ack in DRAIN before any new grant is issued.
module sdram_arbiter #(
    parameter int unsigned ADDR_WIDTH = 25
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  a_access,
    input  logic                  a_wr_en,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [15:0]           a_data_in,
    input  logic [1:0]            a_bytesel,
    output logic [15:0]           a_data_out,
    output logic                  a_ack,

    input  logic                  b_access,
    input  logic                  b_wr_en,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [15:0]           b_data_in,
    input  logic [1:0]            b_bytesel,
    output logic [15:0]           b_data_out,
    output logic                  b_ack,

    output logic                  m_oe,
    output logic                  m_we,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [15:0]           m_din,
    output logic [1:0]            m_bytesel,
    input  logic [15:0]           m_dout,
    input  logic                  m_ack,
    input  logic                  m_configdone
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BUSY  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]            state_q, state_d;
    logic                  last_b_q, last_b_d;
    logic                  gnt_b_q, gnt_b_d;
    logic                  rd_q, rd_d;
    logic                  m_oe_q, m_oe_d;
    logic                  m_we_q, m_we_d;
    logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
    logic [15:0]           m_din_q, m_din_d;
    logic [1:0]            m_bytesel_q, m_bytesel_d;
    logic                  a_ack_q, a_ack_d;
    logic                  b_ack_q, b_ack_d;
    logic [15:0]           a_data_out_q, a_data_out_d;
    logic [15:0]           b_data_out_q, b_data_out_d;
    logic                  grant_b;

    // B wins when it is alone, or on a tie when A was granted last.
    assign grant_b = b_access && (!a_access || !last_b_q);

    always_comb begin
        state_d      = state_q;
        last_b_d     = last_b_q;
        gnt_b_d      = gnt_b_q;
        rd_d         = rd_q;
        m_oe_d       = m_oe_q;
        m_we_d       = m_we_q;
        m_addr_d     = m_addr_q;
        m_din_d      = m_din_q;
        m_bytesel_d  = m_bytesel_q;
        a_ack_d      = 1'b0;
        b_ack_d      = 1'b0;
        a_data_out_d = a_data_out_q;
        b_data_out_d = b_data_out_q;

        case (state_q)
            IDLE: begin
                if (m_configdone && !m_ack && (a_access || b_access)) begin
                    state_d  = BUSY;
                    gnt_b_d  = grant_b;
                    last_b_d = grant_b;
                    m_oe_d   = 1'b1;
                    if (grant_b) begin
                        m_we_d      = b_wr_en;
                        rd_d        = !b_wr_en;
                        m_addr_d    = b_addr;
                        m_din_d     = b_data_in;
                        m_bytesel_d = b_bytesel;
                    end else begin
                        m_we_d      = a_wr_en;
                        rd_d        = !a_wr_en;
                        m_addr_d    = a_addr;
                        m_din_d     = a_data_in;
                        m_bytesel_d = a_bytesel;
                    end
                end
            end
            BUSY: begin
                if (m_ack) begin
                    state_d = DRAIN;
                    m_oe_d  = 1'b0;
                    m_we_d  = 1'b0;
                    if (gnt_b_q) begin
                        b_ack_d = 1'b1;
                        if (rd_q) b_data_out_d = m_dout;
                    end else begin
                        a_ack_d = 1'b1;
                        if (rd_q) a_data_out_d = m_dout;
                    end
                end
            end
            DRAIN: begin
                if (!m_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_b_q     <= 1'b1;
            gnt_b_q      <= 1'b0;
            rd_q         <= 1'b0;
            m_oe_q       <= 1'b0;
            m_we_q       <= 1'b0;
            m_addr_q     <= '0;
            m_din_q      <= '0;
            m_bytesel_q  <= '0;
            a_ack_q      <= 1'b0;
            b_ack_q      <= 1'b0;
            a_data_out_q <= '0;
            b_data_out_q <= '0;
        end else begin
            state_q      <= state_d;
            last_b_q     <= last_b_d;
            gnt_b_q      <= gnt_b_d;
            rd_q         <= rd_d;
            m_oe_q       <= m_oe_d;
            m_we_q       <= m_we_d;
            m_addr_q     <= m_addr_d;
            m_din_q      <= m_din_d;
            m_bytesel_q  <= m_bytesel_d;
            a_ack_q      <= a_ack_d;
            b_ack_q      <= b_ack_d;
            a_data_out_q <= a_data_out_d;
            b_data_out_q <= b_data_out_d;
        end
    end

    assign m_oe       = m_oe_q;
    assign m_we       = m_we_q;
    assign m_addr     = m_addr_q;
    assign m_din      = m_din_q;
    assign m_bytesel  = m_bytesel_q;
    assign a_ack      = a_ack_q;
    assign b_ack      = b_ack_q;
    assign a_data_out = a_data_out_q;
    assign b_data_out = b_data_out_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed vector table, hand-written corner sequences,
// then random two-port traffic against a transaction-level reference model.
module tb_sdram_arbiter;

    localparam int AW = 25;

    logic          clk = 1'b0;
    logic          reset;
    logic          a_access, a_wr_en, b_access, b_wr_en;
    logic [AW-1:0] a_addr, b_addr;
    logic [15:0]   a_data_in, b_data_in, a_data_out, b_data_out;
    logic [1:0]    a_bytesel, b_bytesel;
    logic          a_ack, b_ack;
    logic          m_oe, m_we, m_ack, m_configdone;
    logic [AW-1:0] m_addr;
    logic [15:0]   m_din, m_dout;
    logic [1:0]    m_bytesel;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    sdram_arbiter #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .a_access     (a_access),
        .a_wr_en      (a_wr_en),
        .a_addr       (a_addr),
        .a_data_in    (a_data_in),
        .a_bytesel    (a_bytesel),
        .a_data_out   (a_data_out),
        .a_ack        (a_ack),
        .b_access     (b_access),
        .b_wr_en      (b_wr_en),
        .b_addr       (b_addr),
        .b_data_in    (b_data_in),
        .b_bytesel    (b_bytesel),
        .b_data_out   (b_data_out),
        .b_ack        (b_ack),
        .m_oe         (m_oe),
        .m_we         (m_we),
        .m_addr       (m_addr),
        .m_din        (m_din),
        .m_bytesel    (m_bytesel),
        .m_dout       (m_dout),
        .m_ack        (m_ack),
        .m_configdone (m_configdone)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model state: a transaction is outstanding from grant until the
    // controller acks it; after the ack the extended ack must be seen low once.
    logic          md_busy, md_drain, md_last_b, md_owner_b, md_read;
    logic          e_oe, e_we, e_aack, e_back;
    logic [AW-1:0] e_addr;
    logic [15:0]   e_din, e_ado, e_bdo;
    logic [1:0]    e_bsel;

    task automatic model_reset();
        md_busy = 0; md_drain = 0; md_last_b = 1; md_owner_b = 0; md_read = 0;
        e_oe = 0; e_we = 0; e_aack = 0; e_back = 0;
        e_addr = '0; e_din = '0; e_bsel = '0; e_ado = '0; e_bdo = '0;
    endtask

    task automatic model_step();
        logic win_b;
        e_aack = 0;
        e_back = 0;
        if (md_busy) begin
            if (m_ack) begin
                md_busy  = 0;
                md_drain = 1;
                e_oe     = 0;
                e_we     = 0;
                if (md_owner_b) begin
                    e_back = 1;
                    if (md_read) e_bdo = m_dout;
                end else begin
                    e_aack = 1;
                    if (md_read) e_ado = m_dout;
                end
            end
        end else if (md_drain) begin
            if (!m_ack) md_drain = 0;
        end else if (m_configdone && !m_ack && (a_access || b_access)) begin
            win_b      = (a_access && b_access) ? !md_last_b : b_access;
            md_last_b  = win_b;
            md_owner_b = win_b;
            md_busy    = 1;
            e_oe       = 1;
            e_we       = win_b ? b_wr_en : a_wr_en;
            md_read    = !e_we;
            e_addr     = win_b ? b_addr : a_addr;
            e_din      = win_b ? b_data_in : a_data_in;
            e_bsel     = win_b ? b_bytesel : a_bytesel;
        end
    endtask

    task automatic do_reset();
        reset = 1;
        a_access = 0; a_wr_en = 0; a_addr = '0; a_data_in = '0; a_bytesel = '0;
        b_access = 0; b_wr_en = 0; b_addr = '0; b_data_in = '0; b_bytesel = '0;
        m_ack = 0; m_dout = '0; m_configdone = 0;
        model_reset();
        repeat (2) step();
        check("rst_m_oe", 32'(m_oe), 32'h0);
        check("rst_m_we", 32'(m_we), 32'h0);
        check("rst_m_addr", 32'(m_addr), 32'h0);
        check("rst_m_din", 32'(m_din), 32'h0);
        check("rst_m_bytesel", 32'(m_bytesel), 32'h0);
        check("rst_acks", 32'({a_ack, b_ack}), 32'h0);
        check("rst_a_data_out", 32'(a_data_out), 32'h0);
        check("rst_b_data_out", 32'(b_data_out), 32'h0);
        reset = 0;
    endtask

    // ctl = {m_configdone, a_access, b_access, m_ack}; exp = {oe, we, a_ack, b_ack, sel_b}
    typedef struct {
        logic [3:0]  ctl;
        logic [15:0] dout;
        logic [4:0]  exp;
        logic [15:0] ado;
        logic [15:0] bdo;
    } vec_t;

    vec_t vecs[26];

    int unsigned c_wait, c_hold;
    logic        c_act;
    logic [15:0] c_data;
    logic        a_pend, b_pend;

    initial begin
        do_reset();

        // A: read 0x100; B: write 0x1234 with bytesel 01.
        vecs[0]  = '{4'b0100, 16'h0000, 5'b00000, 16'h0000, 16'h0000};
        vecs[1]  = '{4'b0100, 16'h0000, 5'b00000, 16'h0000, 16'h0000};
        vecs[2]  = '{4'b1100, 16'h0000, 5'b10000, 16'h0000, 16'h0000};
        vecs[3]  = '{4'b1100, 16'h0000, 5'b10000, 16'h0000, 16'h0000};
        vecs[4]  = '{4'b1101, 16'hBEEF, 5'b00100, 16'hBEEF, 16'h0000};
        vecs[5]  = '{4'b1101, 16'hBEEF, 5'b00000, 16'hBEEF, 16'h0000};
        vecs[6]  = '{4'b1101, 16'hBEEF, 5'b00000, 16'hBEEF, 16'h0000};
        vecs[7]  = '{4'b1100, 16'h0000, 5'b00000, 16'hBEEF, 16'h0000};
        vecs[8]  = '{4'b1110, 16'h0000, 5'b11001, 16'hBEEF, 16'h0000};
        vecs[9]  = '{4'b1111, 16'h5555, 5'b00011, 16'hBEEF, 16'h0000};
        vecs[10] = '{4'b1110, 16'h0000, 5'b00000, 16'hBEEF, 16'h0000};
        vecs[11] = '{4'b1110, 16'h0000, 5'b10000, 16'hBEEF, 16'h0000};
        vecs[12] = '{4'b1111, 16'hCAFE, 5'b00100, 16'hCAFE, 16'h0000};
        vecs[13] = '{4'b1110, 16'h0000, 5'b00000, 16'hCAFE, 16'h0000};
        vecs[14] = '{4'b1110, 16'h0000, 5'b11001, 16'hCAFE, 16'h0000};
        vecs[15] = '{4'b1111, 16'h7777, 5'b00011, 16'hCAFE, 16'h0000};
        vecs[16] = '{4'b1110, 16'h0000, 5'b00000, 16'hCAFE, 16'h0000};
        vecs[17] = '{4'b1110, 16'h0000, 5'b10000, 16'hCAFE, 16'h0000};
        vecs[18] = '{4'b0110, 16'h0000, 5'b10000, 16'hCAFE, 16'h0000};
        vecs[19] = '{4'b0111, 16'h0F0F, 5'b00100, 16'h0F0F, 16'h0000};
        vecs[20] = '{4'b0110, 16'h0000, 5'b00000, 16'h0F0F, 16'h0000};
        vecs[21] = '{4'b0110, 16'h0000, 5'b00000, 16'h0F0F, 16'h0000};
        vecs[22] = '{4'b1110, 16'h0000, 5'b11001, 16'h0F0F, 16'h0000};
        vecs[23] = '{4'b1111, 16'h9999, 5'b00011, 16'h0F0F, 16'h0000};
        vecs[24] = '{4'b1000, 16'h0000, 5'b00000, 16'h0F0F, 16'h0000};
        vecs[25] = '{4'b1000, 16'h0000, 5'b00000, 16'h0F0F, 16'h0000};

        a_wr_en = 0; a_addr = 25'h000100; a_data_in = 16'h1111; a_bytesel = 2'b11;
        b_wr_en = 1; b_addr = 25'h000200; b_data_in = 16'h1234; b_bytesel = 2'b01;
        for (int i = 0; i < 26; i++) begin
            {m_configdone, a_access, b_access, m_ack} = vecs[i].ctl;
            m_dout = vecs[i].dout;
            step();
            check($sformatf("vec%0d_m_oe", i), 32'(m_oe), 32'(vecs[i].exp[4]));
            check($sformatf("vec%0d_m_we", i), 32'(m_we), 32'(vecs[i].exp[3]));
            check($sformatf("vec%0d_a_ack", i), 32'(a_ack), 32'(vecs[i].exp[2]));
            check($sformatf("vec%0d_b_ack", i), 32'(b_ack), 32'(vecs[i].exp[1]));
            check($sformatf("vec%0d_a_data_out", i), 32'(a_data_out), 32'(vecs[i].ado));
            check($sformatf("vec%0d_b_data_out", i), 32'(b_data_out), 32'(vecs[i].bdo));
            if (vecs[i].exp[4]) begin
                check($sformatf("vec%0d_m_addr", i), 32'(m_addr),
                      vecs[i].exp[0] ? 32'h200 : 32'h100);
                check($sformatf("vec%0d_m_din", i), 32'(m_din),
                      vecs[i].exp[0] ? 32'h1234 : 32'h1111);
                check($sformatf("vec%0d_m_bytesel", i), 32'(m_bytesel),
                      vecs[i].exp[0] ? 32'h1 : 32'h3);
            end
        end

        // Requester inputs change mid-access; the latched request must hold.
        a_addr = 25'h0ABCDE; a_wr_en = 0; a_data_in = 16'h2222; a_bytesel = 2'b10;
        a_access = 1; b_access = 0; m_ack = 0; m_configdone = 1;
        step();
        check("hold_grant_m_oe", 32'(m_oe), 32'h1);
        check("hold_grant_m_addr", 32'(m_addr), 32'h0ABCDE);
        a_addr = 25'h111111; a_data_in = 16'h3333; a_bytesel = 2'b01; a_wr_en = 1;
        repeat (2) begin
            step();
            check("hold_m_oe", 32'(m_oe), 32'h1);
            check("hold_m_addr", 32'(m_addr), 32'h0ABCDE);
            check("hold_m_din", 32'(m_din), 32'h2222);
            check("hold_m_bytesel", 32'(m_bytesel), 32'h2);
            check("hold_m_we", 32'(m_we), 32'h0);
        end
        m_ack = 1; m_dout = 16'hA5A5;
        step();
        check("hold_done_m_oe", 32'(m_oe), 32'h0);
        check("hold_done_a_ack", 32'(a_ack), 32'h1);
        check("hold_done_a_data_out", 32'(a_data_out), 32'hA5A5);
        m_ack = 0; a_access = 0;
        repeat (2) step();

        // Reset while the controller is acking; m_ack stays high after release.
        a_wr_en = 0; a_addr = 25'h000300; a_access = 1;
        step();
        check("rstmid_grant_m_oe", 32'(m_oe), 32'h1);
        m_ack = 1; reset = 1;
        #1;
        check("rstmid_async_m_oe", 32'(m_oe), 32'h0);
        check("rstmid_async_m_we", 32'(m_we), 32'h0);
        step();
        reset = 0;
        repeat (2) begin
            step();
            check("rstmid_wait_m_oe", 32'(m_oe), 32'h0);
            check("rstmid_wait_a_ack", 32'(a_ack), 32'h0);
        end
        m_ack = 0;
        step();
        check("rstmid_regrant_m_oe", 32'(m_oe), 32'h1);
        check("rstmid_regrant_m_addr", 32'(m_addr), 32'h000300);
        m_ack = 1;
        step();
        check("rstmid_ack", 32'(a_ack), 32'h1);
        m_ack = 0; a_access = 0;
        repeat (2) step();

        // Random two-port traffic with a randomized-latency controller.
        do_reset();
        m_configdone = 1;
        c_act = 0; c_wait = 0; c_hold = 0; c_data = '0;
        a_pend = 0; b_pend = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            model_step();
            step();
            check("rnd_m_oe", 32'(m_oe), 32'(e_oe));
            check("rnd_m_we", 32'(m_we), 32'(e_we));
            check("rnd_a_ack", 32'(a_ack), 32'(e_aack));
            check("rnd_b_ack", 32'(b_ack), 32'(e_back));
            check("rnd_a_data_out", 32'(a_data_out), 32'(e_ado));
            check("rnd_b_data_out", 32'(b_data_out), 32'(e_bdo));
            if (e_oe) begin
                check("rnd_m_addr", 32'(m_addr), 32'(e_addr));
                check("rnd_m_din", 32'(m_din), 32'(e_din));
                check("rnd_m_bytesel", 32'(m_bytesel), 32'(e_bsel));
            end

            if (e_aack) a_pend = 0;
            if (e_back) b_pend = 0;
            if (!a_pend && $urandom_range(0, 2) == 0) begin
                a_pend = 1;
                a_wr_en = 1'($urandom); a_addr = AW'($urandom);
                a_data_in = 16'($urandom); a_bytesel = 2'($urandom);
            end
            if (!b_pend && $urandom_range(0, 2) == 0) begin
                b_pend = 1;
                b_wr_en = 1'($urandom); b_addr = AW'($urandom);
                b_data_in = 16'($urandom); b_bytesel = 2'($urandom);
            end
            if (md_busy && !md_owner_b && $urandom_range(0, 3) == 0) begin
                a_addr = AW'($urandom); a_data_in = 16'($urandom);
            end
            if (md_busy && md_owner_b && $urandom_range(0, 3) == 0) begin
                b_addr = AW'($urandom); b_bytesel = 2'($urandom);
            end
            a_access = a_pend;
            b_access = b_pend;
            if ($urandom_range(0, 49) == 0) m_configdone = !m_configdone;

            if (!c_act && e_oe) begin
                c_act  = 1;
                c_wait = $urandom_range(0, 3);
                c_hold = $urandom_range(1, 3);
                c_data = 16'($urandom);
            end
            m_ack  = 0;
            m_dout = 16'($urandom);
            if (c_act) begin
                if (c_wait > 0) begin
                    c_wait--;
                end else if (c_hold > 0) begin
                    m_ack  = 1;
                    m_dout = c_data;
                    c_hold--;
                end else begin
                    c_act = 0;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
